// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared runtime prescaler and period counter (edge or center aligned),
// double-buffered per-channel duty registers and per-channel output polarity.
module pwm_multi_ch #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RES      = 8,
    parameter int unsigned PRESC_W  = 16,
    localparam int unsigned SelW    = $clog2(CHANNELS) | 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                center_mode,
    input  logic                duty_wr,
    input  logic [SelW-1:0]     duty_sel,
    input  logic [RES-1:0]      duty_in,
    input  logic [CHANNELS-1:0] polarity,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [RES-1:0] Max = '1;
    localparam logic [RES-1:0] One = {{(RES-1){1'b0}}, 1'b1};

    typedef enum logic {DirUp, DirDown} dir_e;

    logic [PRESC_W-1:0]  p_q, p_d;
    logic [RES-1:0]      c_q, c_d;
    dir_e                dir_q, dir_d;
    logic                mode_q, mode_d;
    logic [RES-1:0]      shadow_q [CHANNELS];
    logic [RES-1:0]      shadow_d [CHANNELS];
    logic [RES-1:0]      active_q [CHANNELS];
    logic [RES-1:0]      active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] raw;
    logic                ptick_q, ptick_d;
    logic                tick;
    logic                boundary;
    logic                wr_ok;

    // >= so that lowering prescale below the running count forces an immediate tick
    assign tick  = (p_q >= prescale);
    assign wr_ok = duty_wr && (32'(duty_sel) < CHANNELS);

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_ok && (32'(duty_sel) == i)) begin
                shadow_d[i] = duty_in;
            end
        end
    end

    always_comb begin
        p_d      = p_q;
        c_d      = c_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        active_d = active_q;
        ptick_d  = 1'b0;
        boundary = 1'b0;
        if (!ena) begin
            p_d      = '0;
            c_d      = '0;
            dir_d    = DirUp;
            mode_d   = center_mode;
            active_d = shadow_d;
        end else if (tick) begin
            p_d = '0;
            if (!mode_q) begin
                c_d      = c_q + 1'b1;
                boundary = (c_q == Max);
            end else if (dir_q == DirUp) begin
                if (c_q == Max) begin
                    c_d   = c_q - 1'b1;
                    dir_d = DirDown;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end else begin
                if (c_q <= One) begin
                    c_d      = '0;
                    dir_d    = DirUp;
                    boundary = (c_q == One);
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
        end else begin
            p_d = p_q + 1'b1;
        end

        // shadow_d already holds any same-cycle write, giving the boundary bypass
        if (boundary) begin
            ptick_d  = 1'b1;
            active_d = shadow_d;
            mode_d   = center_mode;
            if (center_mode != mode_q) begin
                c_d   = '0;
                dir_d = DirUp;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            raw[i] = (c_q < active_q[i]);
        end
        pwm_d = ena ? (raw ^ polarity) : polarity;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            c_q     <= '0;
            dir_q   <= DirUp;
            mode_q  <= 1'b0;
            pwm_q   <= '0;
            ptick_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            p_q     <= p_d;
            c_q     <= c_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            pwm_q   <= pwm_d;
            ptick_q <= ptick_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = ptick_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: edge/center periods, double buffering, polarity, enable,
// runtime prescale and reset, with hand-computed expectations.
module tb_pwm_multi_ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] prescale;
    logic        center_mode;
    logic        duty_wr;
    logic [2:0]  duty_sel;
    logic [7:0]  duty_in;
    logic [3:0]  polarity;
    logic [3:0]  pwm_out;
    logic        period_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int hi_cnt [4];
    int tk_cnt;
    int st;

    always #5 clk = ~clk;

    pwm_multi_ch #(
        .CHANNELS (4),
        .RES      (8),
        .PRESC_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .prescale    (prescale),
        .center_mode (center_mode),
        .duty_wr     (duty_wr),
        .duty_sel    (duty_sel),
        .duty_in     (duty_in),
        .polarity    (polarity),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input logic [2:0] sel, input logic [7:0] val);
        duty_wr  = 1'b1;
        duty_sel = sel;
        duty_in  = val;
        step(1);
        duty_wr  = 1'b0;
    endtask

    task automatic wait_tick(input int bound, output int steps);
        steps = 0;
        do begin
            step(1);
            steps++;
        end while (period_tick !== 1'b1 && steps < bound);
    endtask

    // Counts high samples per channel over n cycles; optional write / mode change at iteration
    task automatic measure(input int n, input int wr_at, input logic [2:0] wsel,
                           input logic [7:0] wval, input int cm_at, input logic cm_val);
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        tk_cnt = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
            if (period_tick === 1'b1) tk_cnt++;
            if (i == wr_at) begin
                duty_wr  = 1'b1;
                duty_sel = wsel;
                duty_in  = wval;
            end
            if (i == cm_at) center_mode = cm_val;
            step(1);
            duty_wr = 1'b0;
        end
    endtask

    task automatic check_meas(input string tag, input int e0, input int e1, input int e2,
                              input int e3);
        check({tag, ".hi0"}, hi_cnt[0], e0);
        check({tag, ".hi1"}, hi_cnt[1], e1);
        check({tag, ".hi2"}, hi_cnt[2], e2);
        check({tag, ".hi3"}, hi_cnt[3], e3);
        check({tag, ".ticks"}, tk_cnt, 1);
        check({tag, ".end_tick"}, 32'(period_tick), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ena         = 1'($urandom);
        center_mode = 1'($urandom);
        duty_wr     = 1'($urandom);
        duty_sel    = 3'($urandom);
        duty_in     = 8'($urandom);
        polarity    = 4'($urandom);
        prescale    = 16'($urandom);
        step(3);
        check("rst.pwm", 32'(pwm_out), 0);
        check("rst.tick", 32'(period_tick), 0);

        rst_n       = 1'b1;
        ena         = 1'b0;
        center_mode = 1'b0;
        duty_wr     = 1'b0;
        duty_sel    = 3'd0;
        duty_in     = 8'd0;
        polarity    = 4'b0000;
        prescale    = 16'd0;
        step(1);
        check("idle.pwm", 32'(pwm_out), 0);
        write_duty(3'd0, 8'd64);
        write_duty(3'd1, 8'd32);
        write_duty(3'd2, 8'd100);

        // Edge mode, prescale 0
        ena = 1'b1;
        step(1);
        check("start.pwm", 32'(pwm_out), 4'b0111);
        check("start.tick", 32'(period_tick), 0);
        wait_tick(300, st);
        check("edge.first_tick", st, 255);
        measure(256, 100, 3'd1, 8'd200, -1, 1'b0);
        check_meas("edge.p1", 64, 32, 100, 0);
        measure(256, 255, 3'd0, 8'd128, -1, 1'b0);
        check_meas("edge.p2", 64, 200, 100, 0);
        measure(256, -1, 3'd0, 8'd0, 10, 1'b1);
        check_meas("edge.p3", 128, 200, 100, 0);

        // Center mode, prescale 1; ch3 duty 0 inverted
        prescale = 16'd1;
        polarity = 4'b1000;
        wait_tick(1100, st);
        check("ctr.first_tick", st, 1020);
        check("ctr.pwm_at_tick", 32'(pwm_out), 4'b1111);
        measure(1020, 100, 3'd4, 8'd50, -1, 1'b0);
        check_meas("ctr.p1", 510, 798, 398, 1020);

        // Drop enable mid-period
        step(37);
        ena = 1'b0;
        step(1);
        check("off.pwm", 32'(pwm_out), 4'b1000);
        check("off.tick", 32'(period_tick), 0);
        step(5);
        check("off.pwm2", 32'(pwm_out), 4'b1000);

        // Re-enable in edge mode
        polarity    = 4'b0000;
        center_mode = 1'b0;
        prescale    = 16'd0;
        step(1);
        ena = 1'b1;
        step(1);
        check("reen.pwm", 32'(pwm_out), 4'b0111);
        check("reen.tick", 32'(period_tick), 0);
        wait_tick(300, st);
        check("reen.first_tick", st, 255);
        measure(256, -1, 3'd0, 8'd0, -1, 1'b0);
        check_meas("reen.p1", 128, 200, 100, 0);

        // Runtime prescale: 9 -> 2 while p=7
        step(127);
        check("ps.pre", 32'(pwm_out[0]), 1);
        prescale = 16'd9;
        step(7);
        prescale = 16'd2;
        step(1);
        check("ps.forced0", 32'(pwm_out[0]), 1);
        step(1);
        check("ps.forced1", 32'(pwm_out[0]), 0);
        step(215);
        check("ps.ch1_hi", 32'(pwm_out[1]), 1);
        step(1);
        check("ps.ch1_lo", 32'(pwm_out[1]), 0);
        wait_tick(400, st);
        check("ps.tick", st, 167);

        // Reset mid-period with a simultaneous write
        rst_n    = 1'b0;
        duty_wr  = 1'b1;
        duty_sel = 3'd0;
        duty_in  = 8'd77;
        step(1);
        duty_wr  = 1'b0;
        check("rst2.pwm", 32'(pwm_out), 0);
        check("rst2.tick", 32'(period_tick), 0);
        rst_n    = 1'b1;
        ena      = 1'b0;
        step(1);
        ena      = 1'b1;
        prescale = 16'd0;
        step(1);
        check("rst2.after", 32'(pwm_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
